// File: rtl/ariane_pkg.sv
// Shared rename/commit definitions: physical register file size, the physical
// register index type and the reset value of the committed map.
package ariane_pkg;

  localparam int unsigned NR_PREGS = 64;
  localparam int unsigned PREG_W   = $clog2(NR_PREGS);

  typedef logic [PREG_W-1:0] preg_t;

  // Identity mapping: architectural register i lives in physical register i
  // after reset, and free-list slot k initially holds physical register 32+k.
  function automatic preg_t reset_map(input int unsigned idx);
    return preg_t'(idx);
  endfunction

endpackage

// File: rtl/preg_free_ring.sv
// Physical-register free ring.
// Holds the storage and the three wrap-bit pointers:
//   spec_head   next entry handed to rename
//   commit_head oldest entry whose allocation is not yet committed
//   tail        next write slot for a freed register
// Supports several pushes per cycle (one per commit port, packed in port
// order), one pop per cycle, and a checkpoint restore that rewinds spec_head
// to this cycle's post-commit commit_head. Each push also advances
// commit_head, because every register freed at commit retires exactly one
// allocation.
module preg_free_ring
  import ariane_pkg::*;
#(
  parameter  int unsigned NR_PUSH  = 2,
  parameter  int unsigned FL_DEPTH = 32,
  parameter  int unsigned DW       = 6,
  localparam int unsigned PTR_W    = $clog2(FL_DEPTH) + 1,
  localparam int unsigned IDX_W    = PTR_W - 1,
  localparam int unsigned CNT_W    = $clog2(FL_DEPTH + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NR_PUSH-1:0]          i_push_vld,
  input  logic [NR_PUSH-1:0][DW-1:0]  i_push_data,
  input  logic                        i_pop,
  input  logic                        i_restore,
  output logic [DW-1:0]               o_head_data,
  output logic                        o_empty,
  output logic [CNT_W-1:0]            o_free_cnt
);

  logic [DW-1:0]                r_ring [FL_DEPTH];
  logic [PTR_W-1:0]             r_spec_head;
  logic [PTR_W-1:0]             r_commit_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_free_cnt;

  logic [PTR_W-1:0]             w_tail_nxt;
  logic [PTR_W-1:0]             w_commit_head_nxt;
  logic [PTR_W-1:0]             w_spec_head_nxt;
  logic [NR_PUSH-1:0][IDX_W-1:0] w_wr_idx;

  // Pack valid pushes into consecutive slots starting at tail; derive the
  // next value of every pointer (restore wins over pop).
  always_comb begin
    w_tail_nxt = r_tail;
    w_wr_idx   = '0;
    for (int p = 0; p < NR_PUSH; p++) begin
      w_wr_idx[p] = w_tail_nxt[IDX_W-1:0];
      if (i_push_vld[p]) begin
        w_tail_nxt = w_tail_nxt + 1'b1;
      end
    end
    w_commit_head_nxt = r_commit_head + (w_tail_nxt - r_tail);
    if (i_restore) begin
      w_spec_head_nxt = w_commit_head_nxt;
    end else if (i_pop) begin
      w_spec_head_nxt = r_spec_head + 1'b1;
    end else begin
      w_spec_head_nxt = r_spec_head;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PTR_W'(FL_DEPTH);
      r_free_cnt    <= CNT_W'(FL_DEPTH);
    end else begin
      r_spec_head   <= w_spec_head_nxt;
      r_commit_head <= w_commit_head_nxt;
      r_tail        <= w_tail_nxt;
      r_free_cnt    <= CNT_W'(w_tail_nxt - w_spec_head_nxt);
    end
  end

  // Ring storage: reloaded with 32..NR_PREGS-1 on reset, written at tail on push.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_ring[i] <= DW'(reset_map(32 + i));
      end
    end else begin
      for (int p = 0; p < NR_PUSH; p++) begin
        if (i_push_vld[p]) begin
          r_ring[w_wr_idx[p]] <= i_push_data[p];
        end
      end
    end
  end

  assign o_head_data = r_ring[r_spec_head[IDX_W-1:0]];
  assign o_empty     = (r_spec_head == r_tail);
  assign o_free_cnt  = r_free_cnt;

`ifndef SYNTHESIS
  // The ring can never hold more uncommitted-plus-free entries than slots.
  a_ring_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (PTR_W'(r_tail - r_commit_head) <= PTR_W'(FL_DEPTH)));
`endif

endmodule

// File: rtl/phys_reg_reclaim.sv
// Commit-side physical register reclamation.
// Owns the committed architectural map and the free list (preg_free_ring).
// Commit ports are applied oldest-first; each one reads the map as already
// updated by lower ports, frees the old mapping and installs its own register.
// A flush rewinds the allocation pointer to the post-commit position so every
// uncommitted allocation is offered again; rename restores from arch_map_o.
// Optional feature macro: PREG_RECLAIM_BYPASS_EN -- when the ring is empty,
// hand the lowest-port register freed this cycle straight to rename.
module phys_reg_reclaim #(
  parameter  int unsigned NR_COMMIT_PORTS = 2,
  parameter  int unsigned NR_PREGS        = ariane_pkg::NR_PREGS,
  localparam int unsigned PREG_W          = $clog2(NR_PREGS),
  localparam int unsigned FL_DEPTH        = NR_PREGS - 32,
  localparam int unsigned CNT_W           = $clog2(FL_DEPTH + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  output logic                                    alloc_valid_o,
  output logic [PREG_W-1:0]                       alloc_preg_o,
  input  logic                                    alloc_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0]              commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]         commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0][PREG_W-1:0]  commit_preg_i,
  output logic [31:0][PREG_W-1:0]                 arch_map_o,
  output logic [CNT_W-1:0]                        free_count_o
);

  logic [31:0][PREG_W-1:0]                r_arch_map;
  logic [31:0][PREG_W-1:0]                w_map_nxt;
  logic [NR_COMMIT_PORTS-1:0]             w_commit_eff;
  logic [NR_COMMIT_PORTS-1:0][PREG_W-1:0] w_old_preg;
  logic                                   w_ring_empty;
  logic [PREG_W-1:0]                      w_head_preg;
  logic                                   w_pop;

  // Port-order commit chain: x0 writes are dropped, later ports see the map
  // as rewritten by earlier ports in the same cycle.
  always_comb begin
    w_map_nxt    = r_arch_map;
    w_commit_eff = '0;
    w_old_preg   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      w_commit_eff[p] = commit_valid_i[p] && (commit_rd_i[p] != 5'd0);
      if (w_commit_eff[p]) begin
        w_old_preg[p]              = w_map_nxt[commit_rd_i[p]];
        w_map_nxt[commit_rd_i[p]]  = commit_preg_i[p];
      end
    end
  end

  // Allocation offer and pop; the flush cycle neither offers nor consumes.
  always_comb begin
    alloc_valid_o = !w_ring_empty && !flush_i;
    alloc_preg_o  = w_head_preg;
`ifdef PREG_RECLAIM_BYPASS_EN
    // Descending scan so the lowest freeing port wins. The freed register is
    // still pushed at tail (the same slot spec_head steps over), so a later
    // flush rollback re-offers the correct register.
    if (w_ring_empty && !flush_i) begin
      for (int p = NR_COMMIT_PORTS - 1; p >= 0; p--) begin
        if (w_commit_eff[p]) begin
          alloc_valid_o = 1'b1;
          alloc_preg_o  = w_old_preg[p];
        end
      end
    end
`endif
    w_pop = alloc_valid_o && alloc_ack_i && !flush_i;
  end

  // Committed map register; holds cycle-N commits from cycle N+1 on.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        r_arch_map[i] <= PREG_W'(ariane_pkg::reset_map(i));
      end
    end else begin
      r_arch_map <= w_map_nxt;
    end
  end

  preg_free_ring #(
    .NR_PUSH  (NR_COMMIT_PORTS),
    .FL_DEPTH (FL_DEPTH),
    .DW       (PREG_W)
  ) u_ring (
    .i_clk       (clk_i),
    .i_rst_n     (rst_ni),
    .i_push_vld  (w_commit_eff),
    .i_push_data (w_old_preg),
    .i_pop       (w_pop),
    .i_restore   (flush_i),
    .o_head_data (w_head_preg),
    .o_empty     (w_ring_empty),
    .o_free_cnt  (free_count_o)
  );

  assign arch_map_o = r_arch_map;

endmodule

// File: tb/tb_phys_reg_reclaim.sv
// Bench for phys_reg_reclaim: queue-based reference model, per-cycle compare
// process, directed literal scenarios and a randomized phase.
module tb_phys_reg_reclaim;

  localparam int NCP = 2;
  localparam int PW  = 6;
`ifdef PREG_RECLAIM_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      flush_i = 1'b0;
  logic                      alloc_valid_o;
  logic [PW-1:0]             alloc_preg_o;
  logic                      alloc_ack_i = 1'b0;
  logic [NCP-1:0]            commit_valid_i = '0;
  logic [NCP-1:0][4:0]       commit_rd_i = '0;
  logic [NCP-1:0][PW-1:0]    commit_preg_i = '0;
  logic [31:0][PW-1:0]       arch_map_o;
  logic [5:0]                free_count_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: committed map, speculatively free registers in offer
  // order, and allocated-but-uncommitted registers in allocation order.
  int m_map [32];
  int m_free [$];
  int m_infl [$];

  always #5 clk = ~clk;

  phys_reg_reclaim dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .alloc_valid_o  (alloc_valid_o),
    .alloc_preg_o   (alloc_preg_o),
    .alloc_ack_i    (alloc_ack_i),
    .commit_valid_i (commit_valid_i),
    .commit_rd_i    (commit_rd_i),
    .commit_preg_i  (commit_preg_i),
    .arch_map_o     (arch_map_o),
    .free_count_o   (free_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_free.delete();
    m_infl.delete();
    for (int i = 32; i < 64; i++) m_free.push_back(i);
  endtask

  // One clock of the model, from the inputs present at the edge.
  task automatic model_step();
    bit offer;
    int rd;
    offer = (m_free.size() > 0) && !flush_i;
    for (int p = 0; p < NCP; p++) begin
      rd = int'(commit_rd_i[p]);
      if (commit_valid_i[p] && rd != 0) begin
`ifdef PREG_RECLAIM_BYPASS_EN
        if (m_free.size() == 0 && !flush_i) offer = 1'b1;
`endif
        m_free.push_back(m_map[rd]);
        m_map[rd] = int'(commit_preg_i[p]);
        if (m_infl.size() > 0) void'(m_infl.pop_front());
      end
    end
    if (offer && alloc_ack_i) m_infl.push_back(m_free.pop_front());
    if (flush_i) begin
      m_free = {m_infl, m_free};
      m_infl.delete();
    end
  endtask

  always @(posedge clk) begin
    if (!rst_ni) model_reset();
    else model_step();
  end

  // Per-cycle comparison of every output against the model.
  task automatic compare_outputs();
    bit ev;
    int ep;
    ev = (m_free.size() > 0) && !flush_i;
    ep = ev ? m_free[0] : 0;
`ifdef PREG_RECLAIM_BYPASS_EN
    if (m_free.size() == 0 && !flush_i) begin
      for (int p = NCP - 1; p >= 0; p--) begin
        if (commit_valid_i[p] && commit_rd_i[p] != 5'd0) begin
          ev = 1'b1;
          ep = m_map[int'(commit_rd_i[p])];
        end
      end
    end
`endif
    check("cyc_alloc_valid", {31'd0, alloc_valid_o}, ev);
    if (ev) check("cyc_alloc_preg", {26'd0, alloc_preg_o}, ep);
    check("cyc_free_count", {26'd0, free_count_o}, m_free.size());
    for (int i = 0; i < 32; i++) check("cyc_arch_map", {26'd0, arch_map_o[i]}, m_map[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_ni) compare_outputs();
  end

  task automatic drive(input bit ack, input bit fl, input bit v0, input int rd0, input int p0,
                       input bit v1, input int rd1, input int p1);
    alloc_ack_i       = ack;
    flush_i           = fl;
    commit_valid_i    = {v1, v0};
    commit_rd_i[0]    = 5'(rd0);
    commit_rd_i[1]    = 5'(rd1);
    commit_preg_i[0]  = PW'(p0);
    commit_preg_i[1]  = PW'(p1);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_seq [$];
    bit ack, fl;
    bit v [2];
    int rd [2];
    int pg [2];
    int used;

    rst_ni = 1'b0;
    idle();
    repeat (3) step();
    rst_ni = 1'b1;
    chk_en = 1'b1;
    settle();

    // Reset state
    check("rst_alloc_valid", {31'd0, alloc_valid_o}, 1);
    check("rst_alloc_preg", {26'd0, alloc_preg_o}, 32);
    check("rst_free_count", {26'd0, free_count_o}, 32);
    check("rst_map5", {26'd0, arch_map_o[5]}, 5);
    check("rst_map31", {26'd0, arch_map_o[31]}, 31);

    // Drain the whole free list
    for (int k = 0; k < 32; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("drain_preg", {26'd0, alloc_preg_o}, 32 + k);
      step();
    end
    idle();
    settle();
    check("empty_valid", {31'd0, alloc_valid_o}, 0);
    check("empty_count", {26'd0, free_count_o}, 0);

    // Empty ring, commit rd=3 with ack in the same cycle
    drive(1, 0, 1, 3, 32, 0, 0, 0);
    settle();
    check("byp_valid", {31'd0, alloc_valid_o}, BYP);
    if (BYP == 1) check("byp_preg", {26'd0, alloc_preg_o}, 3);
    step();
    idle();
    settle();
    check("byp_next_count", {26'd0, free_count_o}, 1 - BYP);
    check("byp_next_valid", {31'd0, alloc_valid_o}, 1 - BYP);
    if (BYP == 0) check("byp_next_preg", {26'd0, alloc_preg_o}, 3);

    // Single commit rd=5
    drive(0, 0, 1, 5, 33, 0, 0, 0);
    step();
    idle();
    settle();
    check("c5_map", {26'd0, arch_map_o[5]}, 33);
    check("c5_count", {26'd0, free_count_o}, 2 - BYP);

    // Both ports commit rd=7
    drive(0, 0, 1, 7, 34, 1, 7, 35);
    step();
    idle();
    settle();
    check("c7_map", {26'd0, arch_map_o[7]}, 35);
    check("c7_count", {26'd0, free_count_o}, 4 - BYP);

    // rd=0 commit changes nothing
    drive(0, 0, 1, 0, 50, 0, 0, 0);
    step();
    idle();
    settle();
    check("x0_map", {26'd0, arch_map_o[0]}, 0);
    check("x0_count", {26'd0, free_count_o}, 4 - BYP);

    // Freed registers come back in order: (3,) 5, 7, 34
    if (BYP == 0) exp_seq = '{3, 5, 7, 34};
    else          exp_seq = '{5, 7, 34};
    foreach (exp_seq[k]) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("freed_order", {26'd0, alloc_preg_o}, exp_seq[k]);
      step();
    end
    idle();
    settle();
    check("freed_empty", {31'd0, alloc_valid_o}, 0);

    // Reset in the middle of activity
    drive(1, 0, 1, 9, 36, 1, 10, 37);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    idle();
    settle();
    check("mrst_count", {26'd0, free_count_o}, 32);
    check("mrst_preg", {26'd0, alloc_preg_o}, 32);
    check("mrst_map7", {26'd0, arch_map_o[7]}, 7);

    // Allocate 3, commit 1, then flush together with a second commit
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, 1, 32, 0, 0, 0);
    step();
    drive(1, 1, 1, 2, 33, 0, 0, 0);
    settle();
    check("flush_valid", {31'd0, alloc_valid_o}, 0);
    step();
    idle();
    settle();
    check("flush_preg", {26'd0, alloc_preg_o}, 34);
    check("flush_count", {26'd0, free_count_o}, 32);
    check("flush_map1", {26'd0, arch_map_o[1]}, 32);
    check("flush_map2", {26'd0, arch_map_o[2]}, 33);
    for (int k = 0; k < 30; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    settle();
    check("flush_wrap_preg", {26'd0, alloc_preg_o}, 1);

    // Randomized traffic with realistic in-order commits
    for (int c = 0; c < 4000; c++) begin
      rst_ni = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
      ack = ($urandom_range(3) != 0);
      fl  = ($urandom_range(31) == 0);
      used = 0;
      for (int p = 0; p < 2; p++) begin
        v[p]  = $urandom_range(1) == 1;
        rd[p] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(31));
        pg[p] = int'($urandom_range(63));
        if (v[p] && rd[p] != 0) begin
          if (used < m_infl.size()) begin
            pg[p] = m_infl[used];
            used++;
          end else begin
            v[p] = 1'b0;
          end
        end
      end
      drive(ack, fl, v[0], rd[0], pg[0], v[1], rd[1], pg[1]);
      step();
    end
    rst_ni = 1'b1;
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
